// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud increment helpers
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Rounded BAUD*OVERSAMPLE*2^ACC_W/CLK_FREQ
    function automatic longint calc_inc(input longint clk_freq, input longint baud,
                                        input longint oversample, input int acc_w);
        longint num;
        num = baud * oversample * (longint'(1) << acc_w);
        return (2 * num + clk_freq) / (2 * clk_freq);
    endfunction

    function automatic bit inc_legal(input longint inc, input int acc_w);
        return (inc > 0) && (inc < (longint'(1) << acc_w));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - fractional accumulator oversampling tick generator
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 64000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam longint         INC_L = calc_inc(CLK_FREQ, BAUD, OVERSAMPLE, ACC_W);
    localparam logic [ACC_W:0] INC   = (ACC_W + 1)'(INC_L);

    if (!inc_legal(INC_L, ACC_W)) begin : g_bad_inc
        $error("uart_baud_tick: baud increment out of range");
    end

    logic [ACC_W:0] acc_q, acc_d;

    always_comb acc_d = {1'b0, acc_q[ACC_W-1:0]} + INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign tick_o = acc_q[ACC_W];

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised RS-232 receiver with holding register and gap detect
// Optional break detection output rx_break when UART_RX_BREAK_EN is defined.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 64000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 rx_overrun_clr,
    output logic                 rx_idle,
    output logic                 rx_eop
`ifdef UART_RX_BREAK_EN
    ,
    output logic                 rx_break
`endif
);

    localparam int             CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  HALF     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  LAST     = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]     GAP      = 4'(GAP_BITS);
    localparam parity_e        PAR_MODE = parity_e'(2'(PARITY));

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        GAP_BITS < 1 || GAP_BITS > 15 || (OVERSAMPLE != 8 && OVERSAMPLE != 16)) begin : g_bad_cfg
        $error("uart_rx_param: illegal frame configuration");
    end

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE),
        .ACC_W     (ACC_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    logic                 sync1_q, sync2_q;
    logic [1:0]           samp_q;
    logic                 filt;
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 at_last, done, commit;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, ovr_q, ovr_d;
    logic [3:0]           gap_q, gap_d;
    logic                 eop_q, eop_d;
`ifdef UART_RX_BREAK_EN
    logic                 any1_q, any1_d, brk_q, brk_d, brk_frame;
`endif

    // Majority of the two stored samples and the one being taken on this tick
    assign filt    = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync2_q) | (samp_q[0] & sync2_q);
    assign at_last = tick && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done    = 1'b0;
`ifdef UART_RX_BREAK_EN
        any1_d  = any1_q;
        if (at_last && state_q != ST_IDLE && state_q != ST_START) any1_d = any1_q | filt;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef UART_RX_BREAK_EN
                if (tick && !filt && !brk_q) begin
`else
                if (tick && !filt) begin
`endif
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (tick && cnt_q == HALF) begin
                    if (!filt) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                        stop_d  = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_EN
                        any1_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (at_last) begin
                    shreg_d = {filt, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'(DATA_BITS - 1))
                        state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (at_last) begin
                    perr_d  = filt ^ (^shreg_q) ^ (PAR_MODE == PAR_ODD);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_last) begin
                    ferr_d = ferr_q | ~filt;
                    stop_d = 1'b1;
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef UART_RX_BREAK_EN
    // An all-zero frame is a break: no character, and start detection waits for a 1
    assign brk_frame = done && !any1_q && !filt;
    assign commit    = done && !brk_frame;
    always_comb begin
        brk_d = brk_q;
        if (brk_frame)                brk_d = 1'b1;
        else if (brk_q && tick && filt) brk_d = 1'b0;
    end
    assign rx_break = brk_q;
`else
    assign commit = done;
`endif

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        ovr_d   = ovr_q & ~rx_overrun_clr;
        if (valid_q && rx_ready) valid_d = 1'b0;
        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d  = shreg_q;
                fe_d    = ferr_q | ~filt;
                pe_d    = perr_q;
                valid_d = 1'b1;
            end else begin
                ovr_d   = 1'b1;
            end
        end
        gap_d = gap_q;
        if (state_q != ST_IDLE)                gap_d = '0;
        else if (at_last && gap_q != GAP)      gap_d = gap_q + 4'd1;
        eop_d = (gap_d == GAP) && (gap_q != GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            samp_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            gap_q   <= GAP;
            eop_q   <= 1'b0;
`ifdef UART_RX_BREAK_EN
            any1_q  <= 1'b0;
            brk_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            if (tick) samp_q <= {samp_q[0], sync2_q};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ovr_q   <= ovr_d;
            gap_q   <= gap_d;
            eop_q   <= eop_d;
`ifdef UART_RX_BREAK_EN
            any1_q  <= any1_d;
            brk_q   <= brk_d;
`endif
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_frame_err  = fe_q;
    assign rx_parity_err = pe_q;
    assign rx_overrun    = ovr_q;
    assign rx_idle       = (gap_q == GAP) && (state_q == ST_IDLE);
    assign rx_eop        = eop_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param (three configurations)
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam real CLK_PER = 15.625;
    localparam real BIT_A   = 1.0e9 / 115200.0;
    localparam real BIT_F   = 1000.0;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic clk = 1'b0;
    always #(CLK_PER / 2.0) clk = ~clk;

    logic       rst_n = 1'b0;
    logic       rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic       rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
    logic       clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
    logic [7:0] dat_a, dat_c;
    logic [6:0] dat_b;
    logic       val_a, fe_a, pe_a, ovr_a, idle_a, eop_a;
    logic       val_b, fe_b, pe_b, ovr_b, idle_b, eop_b;
    logic       val_c, fe_c, pe_c, ovr_c, idle_c, eop_c;
`ifdef UART_RX_BREAK_EN
    logic       brk_a, brk_b, brk_c;
`endif

    exp_t exp_q[$];
    int   n_cmp = 0, n_fail = 0;
    int   vcnt_a = 0, vcnt_c = 0, eop_cnt_c = 0, eop_ab = 0;
    logic pval_a = 1'b0, pval_c = 1'b0;
    realtime t_valid_c = 0, t_eop_c = 0;

    uart_rx_param u_a (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(dat_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ovr_a),
        .rx_overrun_clr(clr_a), .rx_idle(idle_a), .rx_eop(eop_a)
`ifdef UART_RX_BREAK_EN
        , .rx_break(brk_a)
`endif
    );

    uart_rx_param #(.BAUD(1000000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(dat_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ovr_b),
        .rx_overrun_clr(clr_b), .rx_idle(idle_b), .rx_eop(eop_b)
`ifdef UART_RX_BREAK_EN
        , .rx_break(brk_b)
`endif
    );

    uart_rx_param #(.BAUD(1000000), .GAP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_c), .rx_data(dat_c), .rx_valid(val_c),
        .rx_ready(rdy_c), .rx_frame_err(fe_c), .rx_parity_err(pe_c), .rx_overrun(ovr_c),
        .rx_overrun_clr(clr_c), .rx_idle(idle_c), .rx_eop(eop_c)
`ifdef UART_RX_BREAK_EN
        , .rx_break(brk_c)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int inst, input logic [8:0] data, input logic fe, input logic pe);
        exp_t e;
        e.inst = inst; e.data = data; e.fe = fe; e.pe = pe;
        exp_q.push_back(e);
    endtask

    task automatic mon(input int inst, input logic [8:0] data, input logic fe, input logic pe);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_char", {4'(inst), 3'b0, data, 2'b0, fe, pe}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("rx_char", {4'(inst), 3'b0, data, 2'b0, fe, pe},
                {4'(e.inst), 3'b0, e.data, 2'b0, e.fe, e.pe});
        end
    endtask

    // Scoreboard monitor: one comparison per accepted character
    always @(negedge clk) begin
        if (val_a && rdy_a) mon(0, {1'b0, dat_a}, fe_a, pe_a);
        if (val_b && rdy_b) mon(1, {2'b0, dat_b}, fe_b, pe_b);
        if (val_c && rdy_c) mon(2, {1'b0, dat_c}, fe_c, pe_c);
        if (val_a && !pval_a) vcnt_a++;
        if (val_c && !pval_c) begin vcnt_c++; t_valid_c = $realtime; end
        if (eop_c) begin eop_cnt_c++; t_eop_c = $realtime; end
        if (eop_a || eop_b) eop_ab++;
        pval_a = val_a;
        pval_c = val_c;
    end

    task automatic drive(input int idx, input logic v);
        case (idx)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic send_bits(input int idx, input logic [15:0] bits, input int n, input real bit_ns);
        for (int i = 0; i < n; i++) begin
            drive(idx, bits[i]);
            #(bit_ns);
        end
        drive(idx, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vals [10];
        int         d, vc0;
        vals = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h7E, 8'h96};

        repeat (5) @(posedge clk);
        #1;
        chk("reset_outputs_c", {dat_c, val_c, fe_c, pe_c, ovr_c, eop_c, idle_c}, {8'h00, 5'b0, 1'b1});
        chk("reset_outputs_b", {dat_b, val_b, idle_b}, {7'h00, 1'b0, 1'b1});
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // 8N1 at 115200 with default parameters
        push(0, 9'h0A5, 1'b0, 1'b0);
        send_bits(0, {1'b1, 8'hA5, 1'b0}, 10, BIT_A);
        #(BIT_A);
        chk("a5_single_valid", vcnt_a, 1);
        wait_drain();

        // 7E2: bad parity, bad second stop bit, clean frame
        push(1, 9'h035, 1'b0, 1'b1);
        send_bits(1, {1'b1, 1'b1, 1'b1, 7'h35, 1'b0}, 11, BIT_F);
        push(1, 9'h035, 1'b1, 1'b0);
        send_bits(1, {1'b0, 1'b1, 1'b0, 7'h35, 1'b0}, 11, BIT_F);
        push(1, 9'h04A, 1'b0, 1'b0);
        send_bits(1, {1'b1, 1'b1, 1'b1, 7'h4A, 1'b0}, 11, BIT_F);
        wait_drain();

        // Quarter-bit glitch, then ten frames 2% fast
        rxd_c = 1'b0;
        #(BIT_F / 4.0);
        rxd_c = 1'b1;
        #(4.0 * BIT_F);
        chk("glitch_back_idle", idle_c, 1);
        for (int i = 0; i < 10; i++) push(2, {1'b0, vals[i]}, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send_bits(2, {1'b1, vals[i], 1'b0}, 10, BIT_F / 1.02);
        wait_drain();
        #(3.0 * BIT_F);

        // Overrun with consumer stalled
        rdy_c = 1'b0;
        push(2, 9'h011, 1'b0, 1'b0);
        send_bits(2, {1'b1, 8'h11, 1'b0}, 10, BIT_F);
        send_bits(2, {1'b1, 8'h22, 1'b0}, 10, BIT_F);
        #(BIT_F);
        chk("overrun_set", ovr_c, 1);
        chk("overrun_keeps_old", {val_c, dat_c}, {1'b1, 8'h11});
        @(posedge clk); #1 clr_c = 1'b1;
        @(posedge clk); #1 clr_c = 1'b0;
        chk("overrun_cleared", ovr_c, 0);
        rdy_c = 1'b1;
        wait_drain();
        #(4.0 * BIT_F);

        // Gap / end-of-packet timing
        eop_cnt_c = 0;
        push(2, 9'h03C, 1'b0, 1'b0);
        send_bits(2, {1'b1, 8'h3C, 1'b0}, 10, BIT_F);
        #(4.0 * BIT_F);
        chk("eop_once", eop_cnt_c, 1);
        chk("idle_after_gap", idle_c, 1);
        d = int'((t_eop_c - t_valid_c) / CLK_PER);
        chk("eop_delay_2bits", (d >= 124 && d <= 132), 1);
        wait_drain();

        // New start bit drops rx_idle; reset in data bit 3 aborts the frame
        vc0 = vcnt_c;
        fork
            send_bits(2, {1'b1, 8'h6B, 1'b0}, 10, BIT_F);
            begin
                #(0.6 * BIT_F);
                chk("idle_drop_on_start", idle_c, 0);
                #(3.9 * BIT_F);
                rst_n = 1'b0;
                #20;
                chk("midframe_reset_outputs", {dat_c, val_c, fe_c, pe_c, ovr_c, eop_c, idle_c},
                    {8'h00, 5'b0, 1'b1});
            end
        join
        #(BIT_F);
        rst_n = 1'b1;
        #(3.0 * BIT_F);
        chk("no_char_after_reset", vcnt_c - vc0, 0);

`ifdef UART_RX_BREAK_EN
        rxd_c = 1'b0;
        #(18.0 * BIT_F);
        chk("break_set", brk_c, 1);
        #(2.0 * BIT_F);
        rxd_c = 1'b1;
        #(BIT_F);
        chk("break_cleared", brk_c, 0);
        chk("break_no_char", vcnt_c - vc0, 0);
        chk("ab_no_break", {brk_a, brk_b}, 0);
`else
        push(2, 9'h000, 1'b1, 1'b0);
        rxd_c = 1'b0;
        #(9.75 * BIT_F);
        rxd_c = 1'b1;
        #(2.0 * BIT_F);
`endif
        push(2, 9'h05A, 1'b0, 1'b0);
        send_bits(2, {1'b1, 8'h5A, 1'b0}, 10, BIT_F);
        wait_drain();
        #(3.0 * BIT_F);
        chk("ab_no_overrun", {ovr_a, ovr_b}, 0);
        chk("ab_idle", {idle_a, idle_b}, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor RS-232 receiver for the serial terminal datapath.
- Oversampling fractional baud generator, input synchroniser and glitch filter.
- Configurable frame: 5-9 data bits, none/even/odd parity, 1 or 2 stop bits.
- Single-entry holding register with valid/ready handshake; framing, parity and overrun flags; idle/end-of-packet detection.
- Sits between the RxD pin and the terminal's character FIFO/decoder.

Parameters:
CLK_FREQ, 64000000, system clock in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; power of two, 8 or 16
ACC_W, 16, baud accumulator fraction width
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 none, 1 even, 2 odd
STOP_BITS, 1, 1 or 2
GAP_BITS, 2, idle bit-times before rx_idle asserts, 1..15

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
rxd  in  1  serial line, idle high, asynchronous to clk
rx_data  out  DATA_BITS  received character, LSB = first bit on the wire
rx_valid  out  1  rx_data and flags hold a character
rx_ready  in  1  consumer accepts when rx_valid && rx_ready
rx_frame_err  out  1  qualified by rx_valid: a stop bit sampled 0
rx_parity_err  out  1  qualified by rx_valid: parity mismatch; always 0 when PARITY=0
rx_overrun  out  1  sticky: a character was lost
rx_overrun_clr  in  1  clears rx_overrun
rx_idle  out  1  no frame for GAP_BITS bit-times
rx_eop  out  1  one-cycle pulse on rx_idle rising

Behaviour:
Reset (rst_n low, asynchronous): FSM=IDLE; accumulator=0; synchroniser and filter=1.
- Output reset values: rx_data=0, rx_valid=0, all flags=0, rx_eop=0, rx_idle=1.

Baud tick:
- INC = round(BAUD*OVERSAMPLE*2^ACC_W/CLK_FREQ), computed at elaboration.
- Accumulator is ACC_W+1 bits. Each clk it takes acc[ACC_W-1:0]+INC; tick = acc[ACC_W].
- Elaboration fails if INC is 0 or INC >= 2^ACC_W.

Input conditioning:
- Two-flop synchroniser on clk.
- 3-sample majority filter clocked on tick. Filtered level = majority of the last 3 samples.

FSM, states IDLE, START, DATA, PARITY, STOP; phase counter cnt of log2(OVERSAMPLE) bits, counting ticks:
- IDLE: filtered=0 on a tick -> START with cnt=0.
- START: at cnt=OVERSAMPLE/2-1, re-check filtered. 0 -> DATA with cnt=0, bit index=0. 1 -> false start, back to IDLE, no flags.
- DATA: at cnt=OVERSAMPLE-1, shift filtered in, LSB first. After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
- PARITY: sample at cnt=OVERSAMPLE-1. Expected bit = XOR of data (even) or its inverse (odd).
- STOP: sample each stop bit at cnt=OVERSAMPLE-1; any 0 sets frame_err. After the last stop sample, commit and go IDLE in the same cycle. This gives half-bit resync margin for back-to-back frames.

Commit (the cycle after the last stop-bit sample):
- If rx_valid=0, or rx_valid && rx_ready in that same cycle: load rx_data and flags, rx_valid=1.
- Otherwise: drop the new character, set rx_overrun; the holding register keeps the old character.
- Accept without commit: rx_valid->0 next cycle; data and flags hold their values.
- rx_overrun_clr and an overrun in the same cycle: set wins.

Gap detection:
- Gap counter runs in bit-times (OVERSAMPLE ticks) only while the FSM is in IDLE.
- Any non-IDLE state clears the counter and rx_idle.
- rx_idle rises when the counter reaches GAP_BITS; saturates, no wrap. rx_eop pulses for exactly one clk on that rising.

Latency: rx_valid rises 1 clk after the tick that samples the last stop bit.

Reset mid-frame: the FSM aborts immediately. No partial character or flag is presented.

Optional Feature:
Macro: UART_RX_BREAK_EN
- Defined: adds output rx_break (1 bit). It sets when a frame is all zeros including the stop bit(s), i.e. line held low for at least one full frame.
  - Such a frame does not commit a character and does not set overrun.
  - rx_break stays high until the filtered line returns 1 for one tick, then clears.
  - The FSM waits in IDLE for filtered=1 before re-arming start detection.
- Undefined: port absent. A break frame is delivered as data 0 with rx_frame_err=1, and start detection re-arms immediately.

Decomposition:
- Package uart_pkg: parity enum (PAR_NONE/PAR_EVEN/PAR_ODD), FSM state enum, and a function computing INC and its legality check. The package is shared with the future TX successor.
- Sub-module uart_baud_tick: accumulator-based tick generator with parameters CLK_FREQ, BAUD, OVERSAMPLE, ACC_W. Reusable by TX.

Test Plan:
1. Defaults (INC=1887). Send 0xA5, 8N1, rx_ready held high -> rx_valid pulses once, rx_data=0xA5, no flags.
2. DATA_BITS=7, PARITY=1 (even), STOP_BITS=2. Send 0x35 with the wrong parity bit -> rx_data=0x35, rx_parity_err=1.
   - Send 0x35 with a 0 in the second stop bit -> rx_frame_err=1.
3. rx_ready=0. Send 0x11 then 0x22 back to back -> rx_data stays 0x11, rx_overrun=1.
   - Pulse rx_overrun_clr -> rx_overrun=0.
4. Low glitch of 1/4 bit-time on idle line -> no rx_valid, FSM back in IDLE.
   - Then 10 back-to-back frames at BAUD+2% -> all 10 received correctly.
5. GAP_BITS=2: after the last stop bit -> rx_eop pulses exactly once, about 2 bit-times later; rx_idle=1.
   - A new start bit -> rx_idle=0.
   - rst_n low mid-frame (bit 3) -> all outputs at reset values, no character delivered.
6. With UART_RX_BREAK_EN: hold rxd low for 2 frame-times -> rx_break=1, no rx_valid.
   - Release line -> rx_break=0; a following 0x5A is received correctly.
   - Without the macro -> data 0x00 with rx_frame_err=1.
